// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx: PS/2 mouse receiver; assembles 3-byte packets into a clamped absolute position and buttons.
// Define MOUSE_INIT_EN to send 0xF4 (enable reporting) and await 0xFA before reception starts.
module ps2_mouse_rx #(
  parameter int MAX_X          = 799,
  parameter int MAX_Y          = 599,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65000,
  parameter int INHIBIT_CYCLES = 6500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        left,
  output logic        right,
  output logic        pkt_valid,
  output logic        err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2((TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES) + 2);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES);
  localparam logic signed [12:0] MAX_XS = 13'(MAX_X);
  localparam logic signed [12:0] MAX_YS = 13'(MAX_Y);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  rx_state_t state, state_nx;
  logic [1:0] clk_sync, data_sync, idx;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [7:0] shreg, b1;
  logic [5:0] hdr;
  logic [2:0] bcnt;
  logic [11:0] xn, yn;
  logic signed [12:0] dx, dy, nx, ny;
  logic filt, strobe, sdata, par, good, byte_done, busy, tout;
  logic rx_en, pkt_en, host_busy, host_clr, inhibit, host_err;

`ifdef MOUSE_INIT_EN
  typedef enum logic [2:0] {H_IDLE, H_INHIBIT, H_REQ, H_SEND, H_ACK, H_RESP, H_DONE} host_state_t;
  localparam logic [TW-1:0] I_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [9:0] TX_FRAME = {1'b1, ~^8'hF4, 8'hF4};
  host_state_t hstate, hstate_nx;
  logic [9:0] tx;
  logic [3:0] tx_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hstate <= H_IDLE;
      tx <= '1;
      tx_n <= '0;
    end else begin
      hstate <= hstate_nx;
      if (hstate == H_SEND && strobe) begin
        tx <= {1'b1, tx[9:1]};
        tx_n <= tx_n + 4'd1;
      end else if (hstate != H_SEND) begin
        tx <= TX_FRAME;
        tx_n <= '0;
      end
    end
  // tx[0] is the bit presented since the last device falling edge; the REQ edge presents bit 0
  always_comb begin
    hstate_nx = hstate;
    host_err = 1'b0;
    unique case (hstate)
      H_IDLE:    hstate_nx = H_INHIBIT;
      H_INHIBIT: hstate_nx = (tcnt == I_LAST) ? H_REQ : H_INHIBIT;
      H_REQ:     hstate_nx = strobe ? H_SEND : H_REQ;
      H_SEND:    hstate_nx = (strobe && tx_n == 4'd8) ? H_ACK : H_SEND;
      H_ACK:     hstate_nx = (strobe && !sdata) ? H_RESP : H_ACK;
      H_RESP:
        if (byte_done) begin
          host_err = !(good && shreg == 8'hFA);
          hstate_nx = host_err ? H_INHIBIT : H_DONE;
        end
      default: ;
    endcase
    if (tout && hstate != H_DONE) hstate_nx = H_INHIBIT;
  end
  assign inhibit = hstate == H_INHIBIT;
  assign host_busy = hstate inside {H_INHIBIT, H_REQ, H_SEND, H_ACK, H_RESP};
  assign host_clr = hstate != hstate_nx;
  assign rx_en = hstate inside {H_RESP, H_DONE};
  assign pkt_en = hstate == H_DONE;
  assign ps2_clk_oe = inhibit;
  assign ps2_data_oe = hstate == H_REQ || (hstate == H_SEND && !tx[0]);
`else
  assign {inhibit, host_busy, host_clr, host_err, ps2_clk_oe, ps2_data_oe} = '0;
  assign {rx_en, pkt_en} = 2'b11;
`endif

  assign busy = state != IDLE || idx != 2'd0 || host_busy;
  assign tout = tcnt == T_LAST && !inhibit;
  assign good = sdata && ^{shreg, par};
  assign byte_done = strobe && state == STOP && rx_en && !tout;
  assign dx = hdr[4] ? 13'sd0 : $signed({{5{hdr[2]}}, b1});
  assign dy = hdr[5] ? 13'sd0 : $signed({{5{hdr[3]}}, shreg});
  assign nx = $signed({1'b0, xpos}) + dx;
  assign ny = $signed({1'b0, ypos}) - dy;
  assign xn = nx[12] ? 12'd0 : (nx > MAX_XS) ? MAX_XS[11:0] : nx[11:0];
  assign yn = ny[12] ? 12'd0 : (ny > MAX_YS) ? MAX_YS[11:0] : ny[11:0];

  // the inhibit phase reuses the timeout counter, so our own clock pull-down must not clear it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clk_sync <= 2'b11;
      data_sync <= 2'b11;
      filt <= 1'b1;
      fcnt <= '0;
      strobe <= 1'b0;
      sdata <= 1'b1;
      tcnt <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      strobe <= 1'b0;
      if (clk_sync[1] == filt) fcnt <= '0;
      else if (fcnt == F_LAST) begin
        filt <= clk_sync[1];
        fcnt <= '0;
        strobe <= filt;
        sdata <= data_sync[1];
      end else fcnt <= fcnt + 1'b1;
      if ((strobe && !inhibit) || !busy || tout || host_clr) tcnt <= '0;
      else tcnt <= tcnt + 1'b1;
    end

  always_comb begin
    state_nx = state;
    if (tout || !rx_en) state_nx = IDLE;
    else if (strobe)
      unique case (state)
        IDLE:    state_nx = sdata ? IDLE : DATA;
        DATA:    state_nx = (bcnt == 3'd7) ? PARITY : DATA;
        PARITY:  state_nx = STOP;
        default: state_nx = IDLE;
      endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      bcnt <= '0;
      par <= 1'b0;
      idx <= '0;
      hdr <= '0;
      b1 <= '0;
      xpos <= '0;
      ypos <= '0;
      left <= 1'b0;
      right <= 1'b0;
      pkt_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      pkt_valid <= 1'b0;
      err <= host_err;
      if (strobe && state == IDLE) bcnt <= '0;
      if (strobe && state == DATA) begin
        shreg <= {sdata, shreg[7:1]};
        bcnt <= bcnt + 3'd1;
      end
      if (strobe && state == PARITY) par <= sdata;
      if (tout) idx <= '0;
      else if (byte_done && pkt_en) begin
        if (!good) begin
          err <= 1'b1;
          idx <= '0;
        end else if (idx == 2'd0) begin
          if (shreg[3]) begin
            hdr <= {shreg[7:4], shreg[1:0]};
            idx <= 2'd1;
          end else err <= 1'b1;
        end else if (idx == 2'd1) begin
          b1 <= shreg;
          idx <= 2'd2;
        end else begin
          idx <= '0;
          pkt_valid <= 1'b1;
          xpos <= xn;
          ypos <= yn;
          left <= hdr[0];
          right <= hdr[1];
        end
      end
    end
endmodule
